top_level_inst: RTL and testbench

//  Fixed-function "program 3" engine: on a req pulse, searches a 32-byte message in its

---
 rtl/prog3_pkg.sv | 21 ++
 rtl/data_mem.sv | 26 ++
 rtl/top_level_inst.sv | 124 ++++++++++++
 tb/tb_top_level_inst.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/prog3_pkg.sv
// Shared definitions for the program-3 pattern-count engine: FSM states,
// fixed memory map and message geometry.
package prog3_pkg;

  localparam int unsigned MSG_LEN  = 32;
  localparam int unsigned PAT_ADDR = 32;
  localparam int unsigned CTB_ADDR = 33;
  localparam int unsigned CTO_ADDR = 34;
  localparam int unsigned CTS_ADDR = 35;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SCAN = 3'd2,
    S_WR33 = 3'd3,
    S_WR34 = 3'd4,
    S_WR35 = 3'd5,
    S_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/data_mem.sv
// Data memory: two combinational read ports, one synchronous write port.
// Contents are never reset.
module data_mem #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [DW-1:0] o_rdata_a,
  output logic [DW-1:0] o_rdata_b
);

  logic [DW-1:0] core [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) core[i_waddr] <= i_wdata;
  end

  assign o_rdata_a = core[i_raddr_a];
  assign o_rdata_b = core[i_raddr_b];

endmodule

// File: rtl/top_level_inst.sv
// Program-3 engine: counts 5-bit pattern matches (in-byte, per-byte, and
// across the whole 256-bit message) and writes the three counts to memory.
module top_level_inst #(
  parameter int unsigned DW      = 8,
  parameter int unsigned AW      = 8,
  parameter int unsigned MSG_LEN = prog3_pkg::MSG_LEN
) (
  input  logic clock,
  input  logic reset_n,
  input  logic req,
  output logic ack
);
  import prog3_pkg::*;

  localparam int unsigned IW = $clog2(MSG_LEN);

  state_t        r_state;
  logic          r_ack;
  logic [4:0]    r_pat;
  logic [7:0]    r_cur;
  logic [IW-1:0] r_idx;
  logic [7:0]    r_ctb, r_cto, r_cts;

  logic          w_we;
  logic [AW-1:0] w_waddr, w_raddr_b;
  logic [DW-1:0] w_wdata, w_rd_a, w_rd_b;
  logic          w_last;
  logic [7:0]    w_nxt;
  logic [15:0]   w_pair;
  logic [2:0]    w_in_hits, w_x_hits, w_x_eff;
  logic          w_unused;

  data_mem #(.DW(DW), .AW(AW)) DM (
    .i_clk    (clock),
    .i_we     (w_we),
    .i_waddr  (w_waddr),
    .i_wdata  (w_wdata),
    .i_raddr_a(AW'(PAT_ADDR)),
    .i_raddr_b(w_raddr_b),
    .o_rdata_a(w_rd_a),
    .o_rdata_b(w_rd_b)
  );

  // Port B fetches byte 0 during LOAD and the look-ahead byte i+1 during SCAN.
  assign w_raddr_b = (r_state == S_SCAN) ? AW'(r_idx) + AW'(1) : '0;
  assign w_last    = (r_idx == IW'(MSG_LEN - 1));
  assign w_nxt     = w_last ? '0 : w_rd_b[7:0];
  assign w_pair    = {r_cur, w_nxt};
  assign w_x_eff   = w_last ? '0 : w_x_hits;
  assign w_unused  = &{1'b0, w_rd_a[2:0]};

  // Offsets 0..3 sit entirely inside byte i; 4..7 straddle into byte i+1.
  always_comb begin
    w_in_hits = '0;
    w_x_hits  = '0;
    for (int unsigned m = 0; m < 8; m++) begin
      if (5'(w_pair >> (11 - m)) == r_pat) begin
        if (m < 4) w_in_hits = w_in_hits + 3'd1;
        else       w_x_hits  = w_x_hits + 3'd1;
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_waddr = AW'(CTB_ADDR);
    w_wdata = DW'(r_ctb);
    case (r_state)
      S_WR33: w_we = 1'b1;
      S_WR34: begin w_we = 1'b1; w_waddr = AW'(CTO_ADDR); w_wdata = DW'(r_cto); end
      S_WR35: begin w_we = 1'b1; w_waddr = AW'(CTS_ADDR); w_wdata = DW'(r_cts); end
      default: w_we = 1'b0;
    endcase
  end

  // ack is registered from DONE, so it rises one edge after DONE is entered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ack   <= 1'b0;
      r_pat   <= '0;
      r_cur   <= '0;
      r_idx   <= '0;
      r_ctb   <= '0;
      r_cto   <= '0;
      r_cts   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (req) begin
            r_state <= S_LOAD;
            r_ack   <= 1'b0;
            r_idx   <= '0;
            r_ctb   <= '0;
            r_cto   <= '0;
            r_cts   <= '0;
          end else if (r_state == S_DONE) begin
            r_ack <= 1'b1;
          end
        end
        S_LOAD: begin
          r_pat   <= w_rd_a[DW-1 -: 5];
          r_cur   <= w_rd_b[7:0];
          r_state <= S_SCAN;
        end
        S_SCAN: begin
          r_ctb <= r_ctb + {5'b0, w_in_hits};
          r_cto <= r_cto + {7'b0, |w_in_hits};
          r_cts <= r_cts + {5'b0, w_in_hits} + {5'b0, w_x_eff};
          r_cur <= w_nxt;
          r_idx <= r_idx + IW'(1);
          if (w_last) r_state <= S_WR33;
        end
        S_WR33:  r_state <= S_WR34;
        S_WR34:  r_state <= S_WR35;
        S_WR35:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ack = r_ack;

endmodule

// File: tb/tb_top_level_inst.sv
// Scoreboard bench for top_level_inst: preloads DM.core, runs the engine and
// compares written counts, ack latency and memory preservation.
`timescale 1ns/1ps
module tb_top_level_inst;
  import prog3_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic req = 1'b0;
  logic ack;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] ctb;
    logic [7:0] cto;
    logic [7:0] cts;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] msg [0:31];
  logic [4:0] pat;
  logic [2:0] junk;

  top_level_inst #(.DW(8), .AW(8), .MSG_LEN(32)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .req    (req),
    .ack    (ack)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic [4:0] p);
    exp_t         e;
    logic [255:0] s;
    logic [255:0] t;
    logic [7:0]   sh;
    int           hits;
    e = '0;
    s = '0;
    for (int b = 0; b < 32; b++) begin
      s = {s[247:0], msg[b]};
      hits = 0;
      for (int j = 0; j < 4; j++) begin
        sh = msg[b] >> j;
        if (sh[4:0] == p) hits++;
      end
      e.ctb = e.ctb + 8'(hits);
      if (hits > 0) e.cto = e.cto + 8'd1;
    end
    for (int k = 0; k < 252; k++) begin
      t = s >> (251 - k);
      if (t[4:0] == p) e.cts = e.cts + 8'd1;
    end
    return e;
  endfunction

  task automatic load_mem();
    @(negedge clock);
    for (int i = 0; i < 32; i++) dut.DM.core[i] = msg[i];
    junk = 3'($urandom);
    dut.DM.core[32] = {pat, junk};
  endtask

  task automatic do_run(input string name, input exp_t e_in);
    int   n;
    exp_t e;
    exp_t got;
    logic bad;
    @(negedge clock);
    req = 1'b1;
    sb.push_back(e_in);
    @(posedge clock);
    #1 req = 1'b0;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL %s ack_drop: got %b want 0", name, ack);
    end
    n = 0;
    while (ack !== 1'b1 && n < 60) begin
      @(posedge clock);
      #1;
      n++;
    end
    checks++;
    if (n != 37) begin
      errors++;
      $display("FAIL %s latency: got %0d want 37", name, n);
    end
    e = sb.pop_front();
    got = {dut.DM.core[33], dut.DM.core[34], dut.DM.core[35]};
    checks++;
    if (got !== e) begin
      errors++;
      $display("FAIL %s counts: got ctb=%0d cto=%0d cts=%0d want ctb=%0d cto=%0d cts=%0d",
               name, got.ctb, got.cto, got.cts, e.ctb, e.cto, e.cts);
    end
    bad = 1'b0;
    for (int i = 0; i < 32; i++) if (dut.DM.core[i] !== msg[i]) bad = 1'b1;
    checks++;
    if (bad || dut.DM.core[32] !== {pat, junk}) begin
      errors++;
      $display("FAIL %s mem_kept: got core[32]=%h corrupt=%b want core[32]=%h corrupt=0",
               name, dut.DM.core[32], bad, {pat, junk});
    end
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 32; i++) msg[i] = v;
  endtask

  task automatic randomize_msg();
    pat = 5'($urandom);
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b want 0", ack);
    end
    checks++;
    if (dut.r_state !== S_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", dut.r_state, S_IDLE);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_fixed();
    pat = 5'b00000; fill(8'h00); load_mem();
    do_run("zeros", '{ctb: 8'd128, cto: 8'd32, cts: 8'd252});
    pat = 5'b11111; fill(8'hFF); load_mem();
    do_run("ones", '{ctb: 8'd128, cto: 8'd32, cts: 8'd252});
    pat = 5'b10101; fill(8'h55); load_mem();
    do_run("alt55", '{ctb: 8'd64, cto: 8'd32, cts: 8'd126});
    pat = 5'b11111; fill(8'h00); load_mem();
    do_run("nomatch", '{ctb: 8'd0, cto: 8'd0, cts: 8'd0});
  endtask

  task automatic test_back_to_back();
    randomize_msg(); load_mem();
    do_run("rand1", model(pat));
    randomize_msg(); load_mem();
    do_run("rand2", model(pat));
    randomize_msg();
    for (int i = 0; i < 32; i += 3) msg[i] = {pat, 3'b101};
    load_mem();
    do_run("rand3", model(pat));
  endtask

  task automatic test_mid_reset();
    exp_t prior;
    exp_t got;
    randomize_msg(); load_mem();
    dut.DM.core[33] = 8'hA5;
    dut.DM.core[34] = 8'h5A;
    dut.DM.core[35] = 8'hC3;
    prior = {8'hA5, 8'h5A, 8'hC3};
    @(negedge clock);
    req = 1'b1;
    @(posedge clock);
    #1 req = 1'b0;
    repeat (12) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ack: got %b want 0", ack);
    end
    checks++;
    if (dut.r_state !== S_IDLE) begin
      errors++;
      $display("FAIL midreset_state: got %0d want %0d", dut.r_state, S_IDLE);
    end
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (45) @(posedge clock);
    #1;
    got = {dut.DM.core[33], dut.DM.core[34], dut.DM.core[35]};
    checks++;
    if (got !== prior) begin
      errors++;
      $display("FAIL midreset_results_kept: got %h want %h", got, prior);
    end
    checks++;
    if (ack !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle_ack: got %b want 0", ack);
    end
    do_run("after_reset", model(pat));
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
